odd_parity_serial_tx: RTL and testbench
=======================================

Name: odd_parity_serial_tx

Overview:
- Serial frame transmitter that sequences the team's OddParityGenerator datapath.
- Accepts one parallel word per valid/ready handshake and computes its odd parity bit at accept time.
- Emits an idle-high serial frame on o_tx: start bit, data LSB first, parity bit, stop bit.
- Sits between a byte-stream producer (FIFO or CPU register) and an external serial pin.

Parameters:
- width, 8, data bits per frame (≥1).
- divisor, 16, clock cycles per serial bit (≥1).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_data  input  width  word to transmit, sampled at the handshake.
- i_valid  input  1  producer has a word on i_data.
- o_ready  output  1  block can accept a word this cycle.
- o_tx  output  1  serial line, idle high.
- o_busy  output  1  a frame is in progress.
- o_parity  output  1  parity bit latched for the current or most recent frame (debug/observability).

Behaviour:
- Reset values (rst high at a clock edge): o_tx=1, o_ready=1, o_busy=0, o_parity=0, state=IDLE, bit and divisor counters=0.
- Reset mid-frame aborts the frame immediately; o_tx returns high on that same edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_ready=1, o_busy=0, o_tx=1.
  - Handshake: i_valid && o_ready at a rising edge.
  - On the handshake, latch i_data into the shift register, latch parity into o_parity, clear counters, go to START.
  - No handshake: stay in IDLE.
- Parity comes from the OddParityGenerator instance on i_data and equals XNOR-reduce of i_data. It makes the count of ones over data+parity odd.
- START: o_tx=0 for divisor cycles, then go to DATA.
- DATA: o_tx = shift register bit 0.
  - Every divisor cycles, shift right one and increment the bit counter.
  - After width bits, go to PARITY.
- PARITY: o_tx=o_parity for divisor cycles, then go to STOP.
- STOP: o_tx=1 for divisor cycles, then go to IDLE.
- Outside IDLE: o_ready=0, o_busy=1, and i_valid/i_data are ignored.
- Latency:
  - o_tx falls on the edge that registers the handshake, so it is observable the cycle after the accept.
  - A frame is exactly (width+3)*divisor cycles from the first low cycle to the end of the stop bit.
  - o_ready is high in the first cycle after the stop bit.
- Back-to-back frames: a producer holding i_valid high gets its next word accepted in that first IDLE cycle. The idle gap is exactly 1 cycle of high o_tx beyond the stop bit.
- Divisor counter:
  - Counts 0..divisor-1; the bit advances when the count reaches divisor-1.
  - Width is clog2(divisor), minimum 1.
  - With divisor=1 every bit lasts one cycle, and the counter logic must still be correct.
- Bit counter width is clog2(width+1).
- Wrap-around: no counter may wrap inside a state; both counters clear on every state transition.
- o_tx, o_ready and o_busy are registered outputs (no combinational path from i_valid to o_tx).
- i_data changing while busy has no effect on the frame in flight.

Decomposition:
- Shared include file holds:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits);
  - the clog2 constant function.
- One sub-module instance: OddParityGenerator with width=width, fed from i_data, output registered into o_parity on accept.
- Shift register, counters and FSM live in odd_parity_serial_tx.

Test Plan:
- Reset check: assert rst for 3 cycles mid-frame (width=8, divisor=4) -> next edge o_tx=1, o_ready=1, o_busy=0; line stays high with i_valid low.
- Accept 0x00, divisor=4 -> o_tx low 4 cycles, then 32 cycles low, then parity=1 for 4, stop high for 4; total 44 cycles; o_ready high on cycle 45.
- Parity values -> 0x01 gives parity 0; 0x07 gives 0; 0xFF gives 1; 0xA5 gives 1. Check o_parity and the serial parity slot.
- Bit order: 0x35 at divisor=1 -> o_tx sequence 0,1,0,1,0,1,1,0,0,1(parity),1(stop); o_busy high exactly 11 cycles.
- Back-to-back: i_valid held high with 0x55 then 0xAA, divisor=2 -> exactly one extra idle-high cycle between frames. i_data changes during frame 1 do not alter its bits.
- Ignore while busy: pulse i_valid with 0x12 mid-frame -> not accepted, o_ready stays 0, current frame unchanged.

Source files
------------

// File: rtl/odd_parity_serial_tx_pkg.sv
// Shared FSM encodings and sizing helper for the odd-parity serial transmitter.
// Pure declarations: no latency or backpressure of its own.
package odd_parity_serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/odd_parity_serial_tx_parity_gen.sv
// Odd parity generator: XNOR-reduce so data plus parity always holds an odd number of ones.
// Purely combinational, zero latency; no backpressure.
module odd_parity_serial_tx_parity_gen #(
  parameter int width = 8
) (
  input  logic [width-1:0] data,
  output logic             parity
);

  assign parity = ~^data;

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Serial transmitter: start, data LSB first, odd parity, stop; (width+3)*divisor cycles per frame.
// o_tx falls on the accept edge; o_ready is low for the whole frame and i_valid is ignored meanwhile.
module odd_parity_serial_tx
  import odd_parity_serial_tx_pkg::*;
#(
  parameter int width   = 8,
  parameter int divisor = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_parity
);

  localparam int DIV_W = clog2(divisor);
  localparam int BIT_W = clog2(width + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(divisor - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(width - 1);

  state_t           state_q;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_nxt;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [BIT_W-1:0] bit_cnt_nxt;
  logic [width-1:0] shift_q;
  logic [width-1:0] shift_nxt;
  logic             parity_nxt;
  logic             gen_parity;
  logic             tx_nxt;
  logic             ready_nxt;
  logic             busy_nxt;
  logic             accept;
  logic             bit_done;

  odd_parity_serial_tx_parity_gen #(
    .width(width)
  ) u_parity_gen (
    .data   (i_data),
    .parity (gen_parity)
  );

  assign accept   = i_valid && o_ready;
  assign bit_done = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_nxt = START;
      START:   if (bit_done) state_nxt = DATA;
      DATA:    if (bit_done && (bit_cnt_q == BIT_LAST)) state_nxt = PARITY;
      PARITY:  if (bit_done) state_nxt = STOP;
      STOP:    if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters restart on every state change, so neither can wrap inside a state.
  always_comb begin
    div_cnt_nxt = div_cnt_q;
    bit_cnt_nxt = bit_cnt_q;
    shift_nxt   = shift_q;
    parity_nxt  = o_parity;
    if (state_nxt != state_q) begin
      div_cnt_nxt = '0;
      bit_cnt_nxt = '0;
    end else if (state_q != IDLE) begin
      div_cnt_nxt = bit_done ? '0 : div_cnt_q + DIV_W'(1);
      if ((state_q == DATA) && bit_done) begin
        bit_cnt_nxt = bit_cnt_q + BIT_W'(1);
      end
    end
    if (accept) begin
      shift_nxt  = i_data;
      parity_nxt = gen_parity;
    end else if ((state_q == DATA) && bit_done) begin
      shift_nxt = shift_q >> 1;
    end
  end

  // Outputs are decoded from the next state and registered, keeping i_valid off any o_tx path.
  always_comb begin
    tx_nxt    = 1'b1;
    ready_nxt = (state_nxt == IDLE);
    busy_nxt  = (state_nxt != IDLE);
    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = parity_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      o_parity  <= 1'b0;
      o_tx      <= 1'b1;
      o_ready   <= 1'b1;
      o_busy    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_nxt;
      bit_cnt_q <= bit_cnt_nxt;
      shift_q   <= shift_nxt;
      o_parity  <= parity_nxt;
      o_tx      <= tx_nxt;
      o_ready   <= ready_nxt;
      o_busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Bench for odd_parity_serial_tx: three instances (divisor 4, 1, 2) checked against a frame-level model.
// Stimulus is driven on the falling edge; outputs are sampled on the falling edge.
module tb_odd_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data [3];
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] par;
  int         cmp_cnt = 0;
  int         err_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    odd_parity_serial_tx #(
      .width   (8),
      .divisor ((g == 0) ? 4 : ((g == 1) ? 1 : 2))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .i_data   (data[g]),
      .i_valid  (valid[g]),
      .o_ready  (ready[g]),
      .o_tx     (tx[g]),
      .o_busy   (busy[g]),
      .o_parity (par[g])
    );
  end

  function automatic int div_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 2);
  endfunction

  // Wait for ready, present a word, let one rising edge take it; returns at the first frame cycle.
  task automatic start(input int k, input logic [7:0] d, input bit hold);
    int t;
    t = 0;
    while (ready[k] !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    cmp_cnt++;
    if (t >= 500) begin
      err_cnt++;
      $display("FAIL start_timeout inst=%0d: ready=%b, required 1", k, ready[k]);
    end
    data[k]  = d;
    valid[k] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid[k] = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: quiet inputs; mode 1: scramble i_data every cycle; mode 2: pulse i_valid with 0x12 mid-frame.
  task automatic check_frame(input int k, input logic [7:0] d, input int mode, input string tag,
                             output logic [63:0] obs);
    int         dv;
    int         n;
    int         busy_hi;
    int         rdy_hi;
    logic       exp_par;
    logic [10:0] bits;
    logic [63:0] expv;
    dv      = div_of(k);
    n       = 11 * dv;
    exp_par = (($countones(d) % 2) == 0);
    bits    = {1'b1, exp_par, d, 1'b0};
    expv    = '0;
    obs     = '0;
    busy_hi = 0;
    rdy_hi  = 0;
    for (int i = 0; i < n; i++) expv[i] = bits[i / dv];
    cmp_cnt++;
    if (par[k] !== exp_par) begin
      err_cnt++;
      $display("FAIL %s_o_parity inst=%0d data=%02h: got %b, required %b", tag, k, d, par[k], exp_par);
    end
    for (int i = 0; i < n; i++) begin
      obs[i] = tx[k];
      if (busy[k] === 1'b1) busy_hi++;
      if (ready[k] !== 1'b0) rdy_hi++;
      if (mode == 1) data[k] = 8'($urandom);
      if (mode == 2 && i == n / 2) begin
        valid[k] = 1'b1;
        data[k]  = 8'h12;
      end
      if (mode == 2 && i == n / 2 + 1) valid[k] = 1'b0;
      @(negedge clk);
    end
    cmp_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s_frame inst=%0d data=%02h: got %h, required %h", tag, k, d, obs, expv);
    end
    cmp_cnt++;
    if (busy_hi != n) begin
      err_cnt++;
      $display("FAIL %s_busy_cycles inst=%0d: got %0d, required %0d", tag, k, busy_hi, n);
    end
    cmp_cnt++;
    if (rdy_hi != 0) begin
      err_cnt++;
      $display("FAIL %s_ready_low inst=%0d: ready high %0d cycles, required 0", tag, k, rdy_hi);
    end
    cmp_cnt++;
    if ({ready[k], tx[k], busy[k]} !== 3'b110) begin
      err_cnt++;
      $display("FAIL %s_idle_after inst=%0d: ready/tx/busy=%b%b%b, required 110", tag, k,
               ready[k], tx[k], busy[k]);
    end
  endtask

  task automatic test_reset();
    logic [63:0] obs;
    int          bad;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if ({tx, ready, busy, par} !== {3'b111, 3'b111, 3'b000, 3'b000}) begin
      err_cnt++;
      $display("FAIL reset_state: tx=%b ready=%b busy=%b parity=%b, required 111 111 000 000",
               tx, ready, busy, par);
    end
    rst = 1'b0;
    @(negedge clk);
    start(0, 8'hFF, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if ({tx[0], ready[0], busy[0], par[0]} !== 4'b1100) begin
      err_cnt++;
      $display("FAIL reset_midframe: tx/ready/busy/parity=%b%b%b%b, required 1100",
               tx[0], ready[0], busy[0], par[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({tx[0], ready[0], busy[0]} !== 3'b110) bad++;
    end
    cmp_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL reset_line_idle: %0d bad cycles, required 0", bad);
    end
    obs = '0;
  endtask

  task automatic test_zero();
    logic [63:0] obs;
    start(0, 8'h00, 1'b0);
    check_frame(0, 8'h00, 0, "zero", obs);
    cmp_cnt++;
    if (obs[43:0] !== {8'hFF, 36'h0}) begin
      err_cnt++;
      $display("FAIL zero_shape: got %h, required %h", obs[43:0], {8'hFF, 36'h0});
    end
  endtask

  task automatic test_parity();
    logic [7:0] vals [4];
    logic       want [4];
    logic [63:0] obs;
    vals = '{8'h01, 8'h07, 8'hFF, 8'hA5};
    want = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      start(2, vals[i], 1'b0);
      cmp_cnt++;
      if (par[2] !== want[i]) begin
        err_cnt++;
        $display("FAIL parity_table data=%02h: got %b, required %b", vals[i], par[2], want[i]);
      end
      check_frame(2, vals[i], 0, "parity", obs);
      cmp_cnt++;
      if (obs[19:18] !== {2{want[i]}}) begin
        err_cnt++;
        $display("FAIL parity_slot data=%02h: got %b, required %b", vals[i], obs[19:18], {2{want[i]}});
      end
    end
  endtask

  task automatic test_bit_order();
    logic [63:0] obs;
    start(1, 8'h35, 1'b0);
    check_frame(1, 8'h35, 0, "bit_order", obs);
    cmp_cnt++;
    if (obs[10:0] !== 11'b110_0110_1010) begin
      err_cnt++;
      $display("FAIL bit_order_seq: got %b, required %b", obs[10:0], 11'b110_0110_1010);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] obs;
    start(2, 8'h55, 1'b1);
    check_frame(2, 8'h55, 1, "b2b_first", obs);
    data[2] = 8'hAA;
    @(posedge clk);
    #1;
    valid[2] = 1'b0;
    @(negedge clk);
    check_frame(2, 8'hAA, 0, "b2b_second", obs);
  endtask

  task automatic test_busy_ignore();
    logic [63:0] obs;
    logic [7:0]  d;
    int          bad;
    d = 8'($urandom);
    start(0, d, 1'b0);
    check_frame(0, d, 2, "busy_ignore", obs);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({tx[0], busy[0]} !== 2'b10) bad++;
    end
    cmp_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL busy_ignore_no_frame: %0d busy cycles after frame, required 0", bad);
    end
  endtask

  task automatic test_random();
    logic [63:0] obs;
    logic [7:0]  d;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 6; j++) begin
        d = 8'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start(k, d, 1'b0);
        check_frame(k, d, 0, "random", obs);
      end
    end
  endtask

  initial begin
    valid = '0;
    for (int k = 0; k < 3; k++) data[k] = '0;
    test_reset();
    test_zero();
    test_parity();
    test_bit_order();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
